// File: rtl/fft_frame_seq.sv
// rtl/fft_frame_seq.sv - frame sequencer for the 512-point FFT: block handshake, stage enables, frame start/done/count
// Optional FFT_SEQ_ERR_EN compiles the sticky ovf_err detector; otherwise ovf_err is tied low.
module fft_frame_seq #(
  parameter int BLK_PER_FRAME = 32,
  parameter int N_STAGE       = 3,
  parameter int STAGE_LAT     = 2,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [N_STAGE-1:0]     stg_en,
  output logic [N_STAGE*5-1:0]   stg_blk,
  output logic                   dout_valid,
  output logic [4:0]             dout_blk,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   ovf_err
);

  localparam int DEPTH = N_STAGE * STAGE_LAT;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [4:0] LAST_BLK = 5'(BLK_PER_FRAME - 1);

  logic [1:0]            state;
  logic [4:0]            blk_cnt;
  logic [DEPTH:0]        pipe_vld;
  logic [DEPTH:0][4:0]   pipe_blk;
  logic                  accept;
  logic                  last_out;

  assign din_ready = ((state == S_IDLE) || (state == S_FILL)) && !rst;
  assign accept    = din_valid && din_ready;
  assign busy      = (state != S_IDLE);
  assign last_out  = pipe_vld[DEPTH] && (pipe_blk[DEPTH] == LAST_BLK);

  // Tap 0 is loaded on the accept edge, so tap j carries a block j cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      blk_cnt     <= '0;
      pipe_vld    <= '0;
      pipe_blk    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[DEPTH-1:0], accept};
      pipe_blk    <= {pipe_blk[DEPTH-1:0], (accept ? blk_cnt : 5'd0)};
      frame_start <= accept && (state == S_IDLE);
      frame_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_FILL;
            blk_cnt <= 5'd1;
          end
        end
        S_FILL: begin
          if (accept) begin
            if (blk_cnt == LAST_BLK) begin
              state   <= S_DRAIN;
              blk_cnt <= '0;
            end else begin
              blk_cnt <= blk_cnt + 5'd1;
            end
          end
        end
        S_DRAIN: begin
          if (last_out) begin
            state      <= S_DONE;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_STAGE; k++) begin : g_tap
      assign stg_en[k]        = pipe_vld[k*STAGE_LAT];
      assign stg_blk[5*k +: 5] = pipe_blk[k*STAGE_LAT];
    end
  endgenerate

  assign dout_valid = pipe_vld[DEPTH];
  assign dout_blk   = pipe_blk[DEPTH];

`ifdef FFT_SEQ_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (din_valid && !din_ready) begin
      ovf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule
